// File: rtl/bsg_manycore_link_sif_buffer.sv
// Two-entry elastic buffer per direction for a vertical manycore link_sif, with an isolate/drain handshake.
// Optional stall counters are enabled by defining BSG_MANYCORE_LINK_SIF_BUFFER_PERF_EN.
module bsg_manycore_link_sif_buffer #(
    parameter int fwd_width_p = 0,
    parameter int rev_width_p = 0
) (
    input  logic                   mc_clk_i,
    input  logic                   mc_reset_n_i,

    input  logic                   fwd_v_i,
    input  logic [fwd_width_p-1:0] fwd_data_i,
    output logic                   fwd_ready_and_o,
    output logic                   fwd_v_o,
    output logic [fwd_width_p-1:0] fwd_data_o,
    input  logic                   fwd_ready_and_i,

    input  logic                   rev_v_i,
    input  logic [rev_width_p-1:0] rev_data_i,
    output logic                   rev_ready_and_o,
    output logic                   rev_v_o,
    output logic [rev_width_p-1:0] rev_data_o,
    input  logic                   rev_ready_and_i,

    input  logic                   isolate_i,
    output logic                   isolated_o
`ifdef BSG_MANYCORE_LINK_SIF_BUFFER_PERF_EN
    ,
    output logic [31:0]            fwd_stall_cnt_o,
    output logic [31:0]            rev_stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ACTIVE   = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } state_e;

    state_e state, state_n;

    logic [fwd_width_p-1:0] fwd_mem [2];
    logic                   fwd_wr, fwd_rd;
    logic [1:0]             fwd_cnt, fwd_cnt_n;
    logic                   fwd_enq, fwd_deq;

    logic [rev_width_p-1:0] rev_mem [2];
    logic                   rev_wr, rev_rd;
    logic [1:0]             rev_cnt, rev_cnt_n;
    logic                   rev_enq, rev_deq;

    logic                   both_empty;

    // Outputs are decodes of registers only; nothing bypasses from the inputs.
    assign fwd_v_o    = (fwd_cnt != 2'd0);
    assign fwd_data_o = fwd_mem[fwd_rd];
    assign rev_v_o    = (rev_cnt != 2'd0);
    assign rev_data_o = rev_mem[rev_rd];
    assign both_empty = (fwd_cnt == 2'd0) && (rev_cnt == 2'd0);

    always_comb begin
        fwd_enq   = fwd_v_i && fwd_ready_and_o;
        fwd_deq   = fwd_v_o && fwd_ready_and_i;
        fwd_cnt_n = fwd_cnt + 2'(fwd_enq) - 2'(fwd_deq);
        rev_enq   = rev_v_i && rev_ready_and_o;
        rev_deq   = rev_v_o && rev_ready_and_i;
        rev_cnt_n = rev_cnt + 2'(rev_enq) - 2'(rev_deq);
    end

    // Isolation FSM next state; dropping isolate_i wins over reaching empty in DRAIN.
    always_comb begin
        state_n = state;
        case (state)
            ACTIVE:   if (isolate_i) state_n = DRAIN;
            DRAIN: begin
                if (!isolate_i)      state_n = ACTIVE;
                else if (both_empty) state_n = ISOLATED;
            end
            ISOLATED: if (!isolate_i) state_n = ACTIVE;
            default:  state_n = ACTIVE;
        endcase
    end

    // Ready is loaded from next-cycle fullness and state so it is a clean register at the boundary.
    always_ff @(posedge mc_clk_i or negedge mc_reset_n_i) begin
        if (!mc_reset_n_i) begin
            state           <= ACTIVE;
            isolated_o      <= 1'b0;
            fwd_ready_and_o <= 1'b0;
            rev_ready_and_o <= 1'b0;
        end else begin
            state           <= state_n;
            isolated_o      <= (state_n == ISOLATED);
            fwd_ready_and_o <= (fwd_cnt_n != 2'd2) && (state_n == ACTIVE);
            rev_ready_and_o <= (rev_cnt_n != 2'd2) && (state_n == ACTIVE);
        end
    end

    always_ff @(posedge mc_clk_i or negedge mc_reset_n_i) begin
        if (!mc_reset_n_i) begin
            fwd_mem[0] <= '0;
            fwd_mem[1] <= '0;
            fwd_wr     <= 1'b0;
            fwd_rd     <= 1'b0;
            fwd_cnt    <= 2'd0;
        end else begin
            if (fwd_enq) begin
                fwd_mem[fwd_wr] <= fwd_data_i;
                fwd_wr          <= ~fwd_wr;
            end
            if (fwd_deq) fwd_rd <= ~fwd_rd;
            fwd_cnt <= fwd_cnt_n;
        end
    end

    always_ff @(posedge mc_clk_i or negedge mc_reset_n_i) begin
        if (!mc_reset_n_i) begin
            rev_mem[0] <= '0;
            rev_mem[1] <= '0;
            rev_wr     <= 1'b0;
            rev_rd     <= 1'b0;
            rev_cnt    <= 2'd0;
        end else begin
            if (rev_enq) begin
                rev_mem[rev_wr] <= rev_data_i;
                rev_wr          <= ~rev_wr;
            end
            if (rev_deq) rev_rd <= ~rev_rd;
            rev_cnt <= rev_cnt_n;
        end
    end

`ifdef BSG_MANYCORE_LINK_SIF_BUFFER_PERF_EN
    logic stall_clr;
    assign stall_clr = (state == ISOLATED) && (state_n == ACTIVE);

    // Saturating counts of cycles where a packet is held back by the downstream side.
    always_ff @(posedge mc_clk_i or negedge mc_reset_n_i) begin
        if (!mc_reset_n_i) begin
            fwd_stall_cnt_o <= 32'd0;
            rev_stall_cnt_o <= 32'd0;
        end else if (stall_clr) begin
            fwd_stall_cnt_o <= 32'd0;
            rev_stall_cnt_o <= 32'd0;
        end else begin
            if (fwd_v_o && !fwd_ready_and_i && (fwd_stall_cnt_o != 32'hFFFF_FFFF))
                fwd_stall_cnt_o <= fwd_stall_cnt_o + 32'd1;
            if (rev_v_o && !rev_ready_and_i && (rev_stall_cnt_o != 32'hFFFF_FFFF))
                rev_stall_cnt_o <= rev_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bsg_manycore_link_sif_buffer.sv
// Self-checking bench: queue-based model of both channels plus directed literal checks.
module tb_bsg_manycore_link_sif_buffer;

    localparam int unsigned FW = 16;
    localparam int unsigned RW = 12;
    localparam int          NPKT = 10000;

    logic          clk, rst_n;
    logic          fwd_v_in, fwd_acc, fwd_v_out, fwd_ds_rdy;
    logic [FW-1:0] fwd_data_in, fwd_data_out;
    logic          rev_v_in, rev_acc, rev_v_out, rev_ds_rdy;
    logic [RW-1:0] rev_data_in, rev_data_out;
    logic          isolate, isolated;
`ifdef BSG_MANYCORE_LINK_SIF_BUFFER_PERF_EN
    logic [31:0]   fwd_stall, rev_stall;
`endif

    bsg_manycore_link_sif_buffer #(.fwd_width_p(FW), .rev_width_p(RW)) dut (
        .mc_clk_i        (clk),
        .mc_reset_n_i    (rst_n),
        .fwd_v_i         (fwd_v_in),
        .fwd_data_i      (fwd_data_in),
        .fwd_ready_and_o (fwd_acc),
        .fwd_v_o         (fwd_v_out),
        .fwd_data_o      (fwd_data_out),
        .fwd_ready_and_i (fwd_ds_rdy),
        .rev_v_i         (rev_v_in),
        .rev_data_i      (rev_data_in),
        .rev_ready_and_o (rev_acc),
        .rev_v_o         (rev_v_out),
        .rev_data_o      (rev_data_out),
        .rev_ready_and_i (rev_ds_rdy),
        .isolate_i       (isolate),
        .isolated_o      (isolated)
`ifdef BSG_MANYCORE_LINK_SIF_BUFFER_PERF_EN
        ,
        .fwd_stall_cnt_o (fwd_stall),
        .rev_stall_cnt_o (rev_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] fdata(input int k);
        return FW'(k * 40503 + 4660);
    endfunction

    function automatic logic [RW-1:0] rdata(input int k);
        return RW'(k * 2654 + 77);
    endfunction

    // Model: each channel is a queue of at most two packets; mode 0=active, 1=draining, 2=isolated.
    logic [FW-1:0] fq[$];
    logic [RW-1:0] rq[$];
    bit exp_fwd_rdy, exp_rev_rdy, exp_iso;
    int mode;
    int fwd_sent, fwd_recv, rev_sent, rev_recv;
    bit m_fa, m_fp, m_ra, m_rp, m_empty;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            rq.delete();
            exp_fwd_rdy = 1'b0;
            exp_rev_rdy = 1'b0;
            exp_iso     = 1'b0;
            mode        = 0;
        end else begin
            m_fa    = fwd_v_in && exp_fwd_rdy;
            m_fp    = (fq.size() > 0) && fwd_ds_rdy;
            m_ra    = rev_v_in && exp_rev_rdy;
            m_rp    = (rq.size() > 0) && rev_ds_rdy;
            m_empty = (fq.size() == 0) && (rq.size() == 0);
            if (mode == 0) begin
                if (isolate) mode = 1;
            end else if (mode == 1) begin
                if (!isolate)     mode = 0;
                else if (m_empty) mode = 2;
            end else begin
                if (!isolate) mode = 0;
            end
            if (m_fp) begin void'(fq.pop_front()); fwd_recv++; end
            if (m_fa) begin fq.push_back(fwd_data_in); fwd_sent++; end
            if (m_rp) begin void'(rq.pop_front()); rev_recv++; end
            if (m_ra) begin rq.push_back(rev_data_in); rev_sent++; end
            exp_fwd_rdy = (fq.size() < 2) && (mode == 0);
            exp_rev_rdy = (rq.size() < 2) && (mode == 0);
            exp_iso     = (mode == 2);
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        chk("fwd_v", 32'(fwd_v_out), 32'(fq.size() != 0));
        chk("fwd_ready", 32'(fwd_acc), 32'(exp_fwd_rdy));
        chk("rev_v", 32'(rev_v_out), 32'(rq.size() != 0));
        chk("rev_ready", 32'(rev_acc), 32'(exp_rev_rdy));
        chk("isolated", 32'(isolated), 32'(exp_iso));
        if (fq.size() != 0) chk("fwd_data", 32'(fwd_data_out), 32'(fq[0]));
        if (rq.size() != 0) chk("rev_data", 32'(rev_data_out), 32'(rq[0]));
        if (!rst_n) begin
            chk("rst_fwd_data", 32'(fwd_data_out), 32'd0);
            chk("rst_rev_data", 32'(rev_data_out), 32'd0);
        end
    end

    int fs0, fr0, rs0, rr0, cyc, k;

    initial begin
        fwd_v_in = 0; fwd_data_in = '0; fwd_ds_rdy = 0;
        rev_v_in = 0; rev_data_in = '0; rev_ds_rdy = 0;
        isolate = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_fwd_v", 32'(fwd_v_out), 32'd0);
        chk("reset_fwd_ready", 32'(fwd_acc), 32'd0);
        chk("reset_rev_ready", 32'(rev_acc), 32'd0);
        chk("reset_isolated", 32'(isolated), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_fwd_ready", 32'(fwd_acc), 32'd1);
        chk("post_reset_rev_ready", 32'(rev_acc), 32'd1);

        // Back-to-back stream with no bubbles
        fwd_ds_rdy = 1; rev_ds_rdy = 1;
        fwd_v_in = 1; fwd_data_in = 16'h11;
        @(negedge clk);
        chk("stream_d0", 32'(fwd_data_out), 32'h11);
        chk("stream_v0", 32'(fwd_v_out), 32'd1);
        fwd_data_in = 16'h22;
        @(negedge clk);
        chk("stream_d1", 32'(fwd_data_out), 32'h22);
        fwd_data_in = 16'h33;
        @(negedge clk);
        chk("stream_d2", 32'(fwd_data_out), 32'h33);
        fwd_v_in = 0;
        @(negedge clk);
        chk("stream_done_v", 32'(fwd_v_out), 32'd0);

        // Fill to two entries under backpressure, then release
        fwd_ds_rdy = 0;
        fwd_v_in = 1; fwd_data_in = 16'hA;
        @(negedge clk);
        fwd_data_in = 16'hB;
        @(negedge clk);
        fwd_data_in = 16'hC;
        chk("full_ready", 32'(fwd_acc), 32'd0);
        chk("full_head_a", 32'(fwd_data_out), 32'hA);
        @(negedge clk);
        chk("full_hold_ready", 32'(fwd_acc), 32'd0);
        fwd_ds_rdy = 1;
        @(negedge clk);
        chk("release_head_b", 32'(fwd_data_out), 32'hB);
        chk("release_ready", 32'(fwd_acc), 32'd1);
        @(negedge clk);
        chk("release_head_c", 32'(fwd_data_out), 32'hC);
        fwd_v_in = 0;
        @(negedge clk);
        chk("release_empty", 32'(fwd_v_out), 32'd0);

        // Random traffic with periodic long fwd stalls
        fs0 = fwd_sent; fr0 = fwd_recv; rs0 = rev_sent; rr0 = rev_recv;
        cyc = 0;
        while (((fwd_recv - fr0) < NPKT || (rev_recv - rr0) < NPKT) && cyc < 60000) begin
            fwd_data_in = fdata(fwd_sent - fs0);
            fwd_v_in    = ((fwd_sent - fs0) < NPKT) && ($urandom_range(3) != 0);
            fwd_ds_rdy  = ((cyc % 1000) < 200) ? 1'b0 : ($urandom_range(3) != 0);
            rev_data_in = rdata(rev_sent - rs0);
            rev_v_in    = ((rev_sent - rs0) < NPKT) && ($urandom_range(3) != 0);
            rev_ds_rdy  = ($urandom_range(3) != 0);
            @(negedge clk);
            cyc++;
        end
        chk("random_fwd_count", 32'(fwd_recv - fr0), 32'(NPKT));
        chk("random_rev_count", 32'(rev_recv - rr0), 32'(NPKT));
        fwd_v_in = 0; rev_v_in = 0; fwd_ds_rdy = 1; rev_ds_rdy = 1;
        repeat (3) @(negedge clk);

        // Isolate with two fwd packets and one rev packet buffered
        fwd_ds_rdy = 0; rev_ds_rdy = 0;
        fwd_v_in = 1; fwd_data_in = 16'h0101;
        rev_v_in = 1; rev_data_in = 12'h0AA;
        @(negedge clk);
        fwd_data_in = 16'h0202; rev_v_in = 0;
        @(negedge clk);
        fwd_v_in = 0;
        isolate = 1;
        @(negedge clk);
        chk("iso_fwd_ready_drop", 32'(fwd_acc), 32'd0);
        chk("iso_rev_ready_drop", 32'(rev_acc), 32'd0);
        fwd_ds_rdy = 1; rev_ds_rdy = 1;
        k = 0;
        while ((fwd_v_out || rev_v_out) && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("iso_drain_cycles", 32'(k), 32'd2);
        chk("iso_not_yet", 32'(isolated), 32'd0);
        @(negedge clk);
        chk("iso_set", 32'(isolated), 32'd1);
        isolate = 0;
        @(negedge clk);
        chk("iso_clear", 32'(isolated), 32'd0);
        chk("iso_fwd_ready_back", 32'(fwd_acc), 32'd1);
        chk("iso_rev_ready_back", 32'(rev_acc), 32'd1);

        // Asynchronous reset with both FIFOs full
        fwd_ds_rdy = 0; rev_ds_rdy = 0;
        fwd_v_in = 1; rev_v_in = 1; fwd_data_in = 16'hDEAD; rev_data_in = 12'hBEE;
        repeat (2) @(negedge clk);
        fwd_v_in = 0; rev_v_in = 0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_fwd_v", 32'(fwd_v_out), 32'd0);
        chk("async_rev_v", 32'(rev_v_out), 32'd0);
        chk("async_fwd_ready", 32'(fwd_acc), 32'd0);
        chk("async_rev_ready", 32'(rev_acc), 32'd0);
        chk("async_fwd_data", 32'(fwd_data_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fwd_ds_rdy = 1; rev_ds_rdy = 1;
        repeat (3) @(negedge clk);
        chk("after_reset_no_stale_fwd", 32'(fwd_v_out), 32'd0);
        chk("after_reset_no_stale_rev", 32'(rev_v_out), 32'd0);

`ifdef BSG_MANYCORE_LINK_SIF_BUFFER_PERF_EN
        fwd_ds_rdy = 0;
        fwd_v_in = 1; fwd_data_in = 16'h0055;
        @(negedge clk);
        fwd_v_in = 0;
        repeat (5) @(negedge clk);
        chk("perf_fwd_stall", fwd_stall, 32'd5);
        chk("perf_rev_stall", rev_stall, 32'd0);
        fwd_ds_rdy = 1;
        isolate = 1;
        k = 0;
        while (!isolated && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("perf_isolated_reached", 32'(isolated), 32'd1);
        isolate = 0;
        @(negedge clk);
        chk("perf_fwd_cleared", fwd_stall, 32'd0);
        chk("perf_rev_cleared", rev_stall, 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
